// File: rtl/mx_pkg.sv
// Shared MX INT8 definitions: block geometry, element/scale types, FSM states.
package mx_pkg;

  localparam int unsigned MX_BLOCK_SIZE  = 32;
  localparam int unsigned MX_ELEM_WIDTH  = 8;
  localparam int unsigned MX_SCALE_WIDTH = 8;

  localparam logic [MX_SCALE_WIDTH-1:0] E8M0_NAN = 8'hFF;

  typedef logic [MX_ELEM_WIDTH-1:0]  t_mx_int8;
  typedef logic [MX_SCALE_WIDTH-1:0] t_scalar;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } t_state;

  // Bits needed to count 0..n inclusive
  function automatic int unsigned zero_cnt_width(input int unsigned n);
    return 32'($clog2(n)) + 32'd1;
  endfunction

endpackage

// File: rtl/mxint8_lane_zero_count.sv
// Combinational popcount of zero-valued lanes within one input beat.
module mxint8_lane_zero_count #(
  parameter  int unsigned LANES      = 4,
  parameter  int unsigned ELEM_WIDTH = 8,
  localparam int unsigned CNT_W      = $clog2(LANES + 1)
) (
  input  logic [LANES*ELEM_WIDTH-1:0] i_data,
  output logic [CNT_W-1:0]            o_zero_cnt_c
);

  always_comb begin
    o_zero_cnt_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (i_data[l*ELEM_WIDTH +: ELEM_WIDTH] == '0) begin
        o_zero_cnt_c = o_zero_cnt_c + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mxint8_block_assembler.sv
// Collects an MX INT8 block from a narrow beat stream and presents the whole
// block (scale, elements, zero count, NaN flag) under valid/ready.
module mxint8_block_assembler
  import mx_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE  = MX_BLOCK_SIZE,
  parameter int unsigned ELEM_WIDTH  = MX_ELEM_WIDTH,
  parameter int unsigned SCALE_WIDTH = MX_SCALE_WIDTH,
  parameter int unsigned LANES       = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [LANES*ELEM_WIDTH-1:0]               in_data,
  input  logic [SCALE_WIDTH-1:0]                    in_scale,
  input  logic                                      in_last,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [SCALE_WIDTH-1:0]                    out_scalar,
  output logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0]     out_elements,
  output logic [zero_cnt_width(BLOCK_SIZE)-1:0]     out_zero_num,
  output logic                                      out_is_nan,
  output logic                                      err_framing
);

  localparam int unsigned BEATS  = BLOCK_SIZE / LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ZW     = zero_cnt_width(BLOCK_SIZE);
  localparam int unsigned LZW    = $clog2(LANES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  t_state                                r_state,        w_state_nxt;
  logic [BEAT_W-1:0]                     r_beat_idx,     w_beat_idx_nxt;
  logic [ZW-1:0]                         r_zero_acc,     w_zero_acc_nxt;
  logic [SCALE_WIDTH-1:0]                r_scale,        w_scale_nxt;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0] r_fill,         w_fill_nxt;
  logic                                  r_out_valid,    w_out_valid_nxt;
  logic [SCALE_WIDTH-1:0]                r_out_scalar,   w_out_scalar_nxt;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0] r_out_elements, w_out_elements_nxt;
  logic [ZW-1:0]                         r_out_zero_num, w_out_zero_num_nxt;
  logic                                  r_out_is_nan,   w_out_is_nan_nxt;
  logic                                  r_err_framing,  w_err_framing_nxt;

  logic [LZW-1:0]                        w_lane_zeros;
  logic                                  w_accept;
  logic                                  w_first;
  logic                                  w_final;
  logic [SCALE_WIDTH-1:0]                w_beat_scale;
  logic [ZW-1:0]                         w_beat_zeros;
  logic [0:BLOCK_SIZE-1][ELEM_WIDTH-1:0] w_beat_elems;

  mxint8_lane_zero_count #(
    .LANES      (LANES),
    .ELEM_WIDTH (ELEM_WIDTH)
  ) u_lane_zero_count (
    .i_data       (in_data),
    .o_zero_cnt_c (w_lane_zeros)
  );

  assign in_ready     = (r_state == FILL);
  assign w_accept     = in_valid && in_ready;
  assign w_first      = (r_beat_idx == '0);
  assign w_final      = (r_beat_idx == LAST_BEAT);
  // Beat 0 starts a new block, so scale and zero count restart from this beat
  assign w_beat_scale = w_first ? in_scale : r_scale;
  assign w_beat_zeros = (w_first ? '0 : r_zero_acc) + ZW'(w_lane_zeros);

  // Next-state and next-value logic for the whole assembler
  always_comb begin
    w_state_nxt        = r_state;
    w_beat_idx_nxt     = r_beat_idx;
    w_zero_acc_nxt     = r_zero_acc;
    w_scale_nxt        = r_scale;
    w_fill_nxt         = r_fill;
    w_out_valid_nxt    = r_out_valid;
    w_out_scalar_nxt   = r_out_scalar;
    w_out_elements_nxt = r_out_elements;
    w_out_zero_num_nxt = r_out_zero_num;
    w_out_is_nan_nxt   = r_out_is_nan;
    w_err_framing_nxt  = 1'b0;

    w_beat_elems = r_fill;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (r_beat_idx == BEAT_W'(b)) begin
        for (int l = 0; l < int'(LANES); l++) begin
          w_beat_elems[b*LANES + l] = in_data[l*ELEM_WIDTH +: ELEM_WIDTH];
        end
      end
    end

    case (r_state)
      FILL: begin
        if (w_accept) begin
          // Flags both an early in_last and a missing one on the final beat
          w_err_framing_nxt = in_last ^ w_final;
          if (w_final) begin
            w_state_nxt        = FULL;
            w_beat_idx_nxt     = '0;
            w_zero_acc_nxt     = '0;
            w_out_valid_nxt    = 1'b1;
            w_out_scalar_nxt   = w_beat_scale;
            w_out_elements_nxt = w_beat_elems;
            w_out_zero_num_nxt = w_beat_zeros;
            w_out_is_nan_nxt   = (w_beat_scale == SCALE_WIDTH'(E8M0_NAN));
          end else if (in_last) begin
            w_beat_idx_nxt = '0;
            w_zero_acc_nxt = '0;
          end else begin
            w_beat_idx_nxt = r_beat_idx + BEAT_W'(1);
            w_zero_acc_nxt = w_beat_zeros;
            w_scale_nxt    = w_beat_scale;
            w_fill_nxt     = w_beat_elems;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          w_state_nxt     = FILL;
          w_out_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= FILL;
      r_beat_idx     <= '0;
      r_zero_acc     <= '0;
      r_scale        <= '0;
      r_fill         <= '0;
      r_out_valid    <= 1'b0;
      r_out_scalar   <= '0;
      r_out_elements <= '0;
      r_out_zero_num <= '0;
      r_out_is_nan   <= 1'b0;
      r_err_framing  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat_idx     <= w_beat_idx_nxt;
      r_zero_acc     <= w_zero_acc_nxt;
      r_scale        <= w_scale_nxt;
      r_fill         <= w_fill_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_out_scalar   <= w_out_scalar_nxt;
      r_out_elements <= w_out_elements_nxt;
      r_out_zero_num <= w_out_zero_num_nxt;
      r_out_is_nan   <= w_out_is_nan_nxt;
      r_err_framing  <= w_err_framing_nxt;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_scalar   = r_out_scalar;
  assign out_elements = r_out_elements;
  assign out_zero_num = r_out_zero_num;
  assign out_is_nan   = r_out_is_nan;
  assign err_framing  = r_err_framing;

endmodule
